// File: rtl/ara_apb_uart_arbiter_pkg.sv
// rtl/ara_apb_uart_arbiter_pkg.sv - shared types and helpers for the UART APB arbiter
package ara_apb_uart_arbiter_pkg;

  localparam int unsigned ApbAddrWidth = 32;
  localparam int unsigned ApbDataWidth = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ApbAddrWidth-1:0] paddr;
    logic [ApbDataWidth-1:0] pwdata;
  } apb_req_t;

  typedef struct packed {
    logic [ApbDataWidth-1:0] prdata;
    logic                    pready;
    logic                    pslverr;
  } apb_resp_t;

  // A timeout of 0 still needs a 1-bit counter so the datapath stays legal.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return ($clog2(cycles + 1) > 1) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/ara_apb_uart_arbiter_if.sv
// rtl/ara_apb_uart_arbiter_if.sv - one APB link; master drives the request, slave answers
interface ara_apb_uart_arbiter_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) ();

  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [AddrWidth-1:0] paddr;
  logic [DataWidth-1:0] pwdata;
  logic [DataWidth-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/ara_apb_uart_arbiter_rr2.sv
// rtl/ara_apb_uart_arbiter_rr2.sv - two-way round-robin picker with last-served pointer
module ara_apb_uart_arbiter_rr2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Index of the requester served last; reset to 1 so requester 0 wins the first tie.
  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/ara_apb_uart_arbiter.sv
// rtl/ara_apb_uart_arbiter.sv - round-robin arbiter of two APB requesters onto the UART slave
module ara_apb_uart_arbiter
  import ara_apb_uart_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth     = ApbAddrWidth,
  parameter int unsigned DataWidth     = ApbDataWidth,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  ara_apb_uart_arbiter_if.slave         m0,
  ara_apb_uart_arbiter_if.slave         m1,
  ara_apb_uart_arbiter_if.master        s,
  output logic [1:0]                    grant_o
);

  localparam int unsigned CntWidth = cnt_width(TimeoutCycles);
  localparam logic [CntWidth-1:0] CntLast =
      CntWidth'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  arb_state_e           state;
  logic                 owner;
  logic [CntWidth-1:0]  cnt;
  logic [1:0]           gnt;
  logic                 timeout_hit;
  logic [DataWidth-1:0] rsp_data;
  logic                 rsp_err;

  ara_apb_uart_arbiter_rr2 u_rr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     ({m1.psel, m0.psel}),
    .advance (state == IDLE),
    .gnt     (gnt)
  );

  assign timeout_hit = (TimeoutCycles != 0) && (cnt == CntLast);

  // A ready slave wins over a simultaneous timeout; writes never return data.
  assign rsp_data = (s.pready && !s.pwrite) ? s.prdata : '0;
  assign rsp_err  = s.pready ? s.pslverr : 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cnt        <= '0;
      grant_o    <= 2'b00;
      s.psel     <= 1'b0;
      s.penable  <= 1'b0;
      s.pwrite   <= 1'b0;
      s.paddr    <= '0;
      s.pwdata   <= '0;
      m0.prdata  <= '0;
      m0.pready  <= 1'b0;
      m0.pslverr <= 1'b0;
      m1.prdata  <= '0;
      m1.pready  <= 1'b0;
      m1.pslverr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            owner     <= gnt[1];
            grant_o   <= gnt;
            s.psel    <= 1'b1;
            s.penable <= 1'b0;
            s.pwrite  <= gnt[1] ? m1.pwrite : m0.pwrite;
            s.paddr   <= gnt[1] ? m1.paddr  : m0.paddr;
            s.pwdata  <= gnt[1] ? m1.pwdata : m0.pwdata;
            state     <= SETUP;
          end
        end
        SETUP: begin
          s.penable <= 1'b1;
          cnt       <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (s.pready || timeout_hit) begin
            s.psel    <= 1'b0;
            s.penable <= 1'b0;
            cnt       <= '0;
            state     <= RESP;
            if (owner) begin
              m1.pready  <= 1'b1;
              m1.prdata  <= rsp_data;
              m1.pslverr <= rsp_err;
            end else begin
              m0.pready  <= 1'b1;
              m0.prdata  <= rsp_data;
              m0.pslverr <= rsp_err;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          m0.prdata  <= '0;
          m0.pready  <= 1'b0;
          m0.pslverr <= 1'b0;
          m1.prdata  <= '0;
          m1.pready  <= 1'b0;
          m1.pslverr <= 1'b0;
          grant_o    <= 2'b00;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ara_apb_uart_arbiter.sv
// tb/tb_ara_apb_uart_arbiter.sv - scoreboard bench for the UART APB arbiter
module tb_ara_apb_uart_arbiter;

  typedef struct {
    int          who;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  grant;
  int          errors = 0;
  int          checks = 0;
  exp_t        sbq[$];

  bit          slave_hang = 1'b0;
  bit          slave_echo = 1'b1;
  bit          slave_err = 1'b0;
  int          slave_waits = 0;
  logic [31:0] slave_rdata = 32'h0;
  int          wait_cnt = 0;

  ara_apb_uart_arbiter_if #(.AddrWidth(32), .DataWidth(32)) m0 ();
  ara_apb_uart_arbiter_if #(.AddrWidth(32), .DataWidth(32)) m1 ();
  ara_apb_uart_arbiter_if #(.AddrWidth(32), .DataWidth(32)) s ();

  ara_apb_uart_arbiter #(
    .AddrWidth     (32),
    .DataWidth     (32),
    .TimeoutCycles (8)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .m0      (m0),
    .m1      (m1),
    .s       (s),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  // Slave model: pready after slave_waits ACCESS cycles; echo mode returns ~paddr.
  always @(posedge clk) begin
    if (s.psel && s.penable) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign s.pready  = s.psel && s.penable && !slave_hang && (wait_cnt >= slave_waits);
  assign s.prdata  = slave_echo ? ~s.paddr : slave_rdata;
  assign s.pslverr = slave_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic sel, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (idx == 0) begin
      m0.psel = sel; m0.penable = 1'b0; m0.pwrite = wr; m0.paddr = addr; m0.pwdata = data;
    end else begin
      m1.psel = sel; m1.penable = 1'b0; m1.pwrite = wr; m1.paddr = addr; m1.pwdata = data;
    end
  endtask

  task automatic wait_resp(input int budget, output int who, output int cyc,
                           output int acc, output bit any0, output bit any1);
    who = -1; cyc = 0; acc = 0; any0 = 1'b0; any1 = 1'b0;
    while (who < 0 && cyc < budget) begin
      step();
      cyc++;
      if (s.psel && s.penable) acc++;
      any0 |= m0.pready || m0.pslverr || (m0.prdata != 32'h0);
      any1 |= m1.pready || m1.pslverr || (m1.prdata != 32'h0);
      if (m0.pready) who = 0;
      else if (m1.pready) who = 1;
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({s.psel, s.penable, grant, m0.pready, m1.pready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000", {s.psel, s.penable, grant, m0.pready, m1.pready});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (grant !== 2'b00 || s.psel !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: grant=%b psel=%b want 00/0", grant, s.psel);
    end
  endtask

  task automatic test_single_write();
    exp_t e;
    slave_echo = 1'b1; slave_waits = 0;
    drive(0, 1, 1, 32'h0, 32'h41);
    sbq.push_back('{0, 32'h0, 1'b0});
    step();
    checks++;
    if ({s.psel, s.penable} !== 2'b10 || grant !== 2'b01) begin
      errors++;
      $display("FAIL setup_phase: psel/penable=%b grant=%b want 10/01", {s.psel, s.penable}, grant);
    end
    checks++;
    if (s.pwrite !== 1'b1 || s.paddr !== 32'h0 || s.pwdata !== 32'h41) begin
      errors++;
      $display("FAIL setup_fields: w=%b a=%h d=%h want 1/0/41", s.pwrite, s.paddr, s.pwdata);
    end
    step();
    checks++;
    if ({s.psel, s.penable} !== 2'b11) begin
      errors++;
      $display("FAIL access_phase: psel/penable=%b want 11", {s.psel, s.penable});
    end
    step();
    checks++;
    if (m0.pready !== 1'b1 || m1.pready !== 1'b0) begin
      errors++;
      $display("FAIL write_latency: m0.pready=%b m1.pready=%b want 1/0 in cycle 3", m0.pready, m1.pready);
    end
    e = sbq.pop_front();
    checks++;
    if (m0.prdata !== e.data || m0.pslverr !== e.err) begin
      errors++;
      $display("FAIL write_resp: prdata=%h pslverr=%b want %h/%b", m0.prdata, m0.pslverr, e.data, e.err);
    end
    drive(0, 0, 0, 0, 0);
    step();
    checks++;
    if (m0.pready !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL resp_pulse: pready=%b grant=%b want 0/00", m0.pready, grant);
    end
  endtask

  task automatic test_read_wait();
    exp_t e;
    int who, cyc, acc;
    bit any0, any1;
    slave_echo = 1'b0; slave_rdata = 32'h60; slave_waits = 3;
    drive(1, 1, 0, 32'h14, 32'h0);
    sbq.push_back('{1, 32'h60, 1'b0});
    wait_resp(20, who, cyc, acc, any0, any1);
    e = sbq.pop_front();
    checks++;
    if (who !== e.who || cyc !== 6) begin
      errors++;
      $display("FAIL read_latency: who=%0d cycle=%0d want %0d/6", who, cyc, e.who);
    end
    checks++;
    if (m1.prdata !== e.data || m1.pslverr !== e.err) begin
      errors++;
      $display("FAIL read_data: prdata=%h pslverr=%b want %h/%b", m1.prdata, m1.pslverr, e.data, e.err);
    end
    checks++;
    if (any0 !== 1'b0) begin
      errors++;
      $display("FAIL read_loser_quiet: m0 activity=%b want 0", any0);
    end
    drive(1, 0, 0, 0, 0);
    step();
    slave_echo = 1'b1; slave_waits = 0;
  endtask

  task automatic test_contention();
    exp_t e;
    int who, cyc, acc;
    bit any0, any1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive(0, 1, 0, 32'h100, 32'h0);
    drive(1, 1, 0, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++)
      sbq.push_back('{i % 2, (i % 2 == 0) ? ~32'h100 : ~32'h200, 1'b0});
    for (int i = 0; i < 4; i++) begin
      wait_resp(20, who, cyc, acc, any0, any1);
      e = sbq.pop_front();
      checks++;
      if (who !== e.who || cyc !== ((i == 0) ? 3 : 4)) begin
        errors++;
        $display("FAIL contention_order[%0d]: who=%0d cycle=%0d want %0d/%0d", i, who, cyc, e.who, (i == 0) ? 3 : 4);
      end
      checks++;
      if (grant !== ((e.who == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL contention_grant[%0d]: grant=%b want owner %0d", i, grant, e.who);
      end
      checks++;
      if (((e.who == 0) ? m0.prdata : m1.prdata) !== e.data) begin
        errors++;
        $display("FAIL contention_data[%0d]: prdata=%h want %h", i, (e.who == 0) ? m0.prdata : m1.prdata, e.data);
      end
      if (i == 3) begin
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
      end
    end
    step();
  endtask

  task automatic test_timeout();
    exp_t e;
    int who, cyc, acc;
    bit any0, any1;
    slave_hang = 1'b1;
    drive(1, 1, 0, 32'h30, 32'h0);
    sbq.push_back('{1, 32'h0, 1'b1});
    wait_resp(30, who, cyc, acc, any0, any1);
    e = sbq.pop_front();
    checks++;
    if (who !== e.who || cyc !== 10 || acc !== 8) begin
      errors++;
      $display("FAIL timeout_timing: who=%0d cycle=%0d access=%0d want %0d/10/8", who, cyc, acc, e.who);
    end
    checks++;
    if (m1.prdata !== e.data || m1.pslverr !== e.err || any0 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_resp: prdata=%h pslverr=%b m0act=%b want %h/%b/0", m1.prdata, m1.pslverr, any0, e.data, e.err);
    end
    drive(1, 0, 0, 0, 0);
    step();
    slave_hang = 1'b0; slave_waits = 7;
    drive(0, 1, 0, 32'h40, 32'h0);
    sbq.push_back('{0, ~32'h40, 1'b0});
    wait_resp(30, who, cyc, acc, any0, any1);
    e = sbq.pop_front();
    checks++;
    if (who !== e.who || cyc !== 10 || m0.prdata !== e.data || m0.pslverr !== e.err) begin
      errors++;
      $display("FAIL ready_beats_timeout: who=%0d cycle=%0d prdata=%h pslverr=%b want %0d/10/%h/%b",
               who, cyc, m0.prdata, m0.pslverr, e.who, e.data, e.err);
    end
    drive(0, 0, 0, 0, 0);
    step();
    slave_waits = 0;
  endtask

  task automatic test_slave_error();
    exp_t e;
    int who, cyc, acc;
    bit any0, any1;
    slave_err = 1'b1; slave_waits = 1;
    drive(0, 1, 0, 32'h8, 32'h0);
    sbq.push_back('{0, ~32'h8, 1'b1});
    wait_resp(20, who, cyc, acc, any0, any1);
    e = sbq.pop_front();
    checks++;
    if (who !== e.who || cyc !== 4 || m0.prdata !== e.data || m0.pslverr !== e.err) begin
      errors++;
      $display("FAIL slave_error: who=%0d cycle=%0d prdata=%h pslverr=%b want %0d/4/%h/%b",
               who, cyc, m0.prdata, m0.pslverr, e.who, e.data, e.err);
    end
    drive(0, 0, 0, 0, 0);
    step();
    slave_err = 1'b0; slave_waits = 0;
    drive(1, 1, 1, 32'hC, 32'h99);
    sbq.push_back('{1, 32'h0, 1'b0});
    wait_resp(20, who, cyc, acc, any0, any1);
    e = sbq.pop_front();
    checks++;
    if (who !== e.who || m1.prdata !== e.data || m1.pslverr !== e.err) begin
      errors++;
      $display("FAIL after_error_clean: who=%0d prdata=%h pslverr=%b want %0d/%h/%b",
               who, m1.prdata, m1.pslverr, e.who, e.data, e.err);
    end
    drive(1, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int who, cyc, acc;
    bit any0, any1;
    slave_hang = 1'b1;
    drive(1, 1, 0, 32'h50, 32'h0);
    repeat (3) step();
    checks++;
    if ({s.psel, s.penable} !== 2'b11) begin
      errors++;
      $display("FAIL mid_access_reached: psel/penable=%b want 11", {s.psel, s.penable});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s.psel, s.penable, grant, m0.pready, m1.pready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async: got %b want 000000", {s.psel, s.penable, grant, m0.pready, m1.pready});
    end
    drive(0, 1, 0, 32'h60, 32'h0);
    step();
    step();
    slave_hang = 1'b0;
    rst_n = 1'b1;
    sbq.push_back('{0, ~32'h60, 1'b0});
    sbq.push_back('{1, ~32'h50, 1'b0});
    for (int i = 0; i < 2; i++) begin
      wait_resp(20, who, cyc, acc, any0, any1);
      e = sbq.pop_front();
      checks++;
      if (who !== e.who || ((e.who == 0) ? m0.prdata : m1.prdata) !== e.data) begin
        errors++;
        $display("FAIL post_reset_grant[%0d]: who=%0d prdata=%h want %0d/%h",
                 i, who, (e.who == 0) ? m0.prdata : m1.prdata, e.who, e.data);
      end
      drive(e.who, 0, 0, 0, 0);
    end
    step();
    checks++;
    if (sbq.size() != 0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL final_idle: pending=%0d grant=%b want 0/00", sbq.size(), grant);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_timeout();
    test_slave_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
